// File: rtl/cola_destinos_pkg.sv
// ============================================================================
// cola_destinos_pkg : floor-code constants and default sizing for the queue
// Rev 1.0
// ============================================================================
`default_nettype none

package cola_destinos_pkg;

  localparam int DEF_DEST_W = 2;
  localparam int DEF_DEPTH  = 16;

  localparam logic [1:0] DEST_MINUS_ONE = 2'b00;
  localparam logic [1:0] DEST_ONE       = 2'b01;
  localparam logic [1:0] DEST_TWO       = 2'b10;
  localparam logic [1:0] DEST_THREE     = 2'b11;

endpackage

`default_nettype wire

// File: rtl/cola_destinos_match.sv
// ============================================================================
// cola_destinos_match : parallel compare of an incoming code against pending slots
// Rev 1.0
// ============================================================================
`default_nettype none

module cola_destinos_match
  import cola_destinos_pkg::*;
#(
  parameter int DEST_W = DEF_DEST_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic [DEST_W-1:0]             dest,
  input  logic [DEPTH-1:0][DEST_W-1:0]  mem,
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0]              excl,
  output logic                          hit
);

  logic [DEPTH-1:0] eq;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign eq[i] = valid[i] & ~excl[i] & (mem[i] == dest);
  end

  assign hit = |eq;

endmodule

`default_nettype wire

// File: rtl/cola_destinos_fifo.sv
// ============================================================================
// cola_destinos_fifo : show-ahead FIFO of floor destinations with optional
//                      duplicate suppression, flush and overflow flags
// Rev 1.0
// ============================================================================
`default_nettype none

module cola_destinos_fifo
  import cola_destinos_pkg::*;
#(
  parameter int DEST_W = DEF_DEST_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DEDUP  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [DEST_W-1:0] push_dest,
  output logic              push_ready,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DEST_W-1:0] destino,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              duplicado,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DEST_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         dup_q, dup_d, ovf_q, ovf_d;
  logic                         push_hs, pop_hs, hit, store;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign destino    = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign duplicado  = dup_q;
  assign overflow   = ovf_q;

  assign push_hs = push_valid & push_ready;
  assign pop_hs  = pop_valid & pop_ready;

  if (DEDUP != 0) begin : g_dedup
    logic [DEPTH-1:0] excl;

    // The head leaving this cycle no longer counts as pending.
    always_comb begin
      excl = '0;
      if (pop_hs) excl[rd_ptr_q] = 1'b1;
    end

    cola_destinos_match #(
      .DEST_W (DEST_W),
      .DEPTH  (DEPTH)
    ) u_match (
      .dest  (push_dest),
      .mem   (mem_q),
      .valid (vld_q),
      .excl  (excl),
      .hit   (hit)
    );
  end else begin : g_nodedup
    assign hit = 1'b0;
  end

  assign store = push_hs & ~hit;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dup_d    = 1'b0;
    ovf_d    = 1'b0;
    if (flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_hs) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = ptr_inc(rd_ptr_q);
      end
      if (store) begin
        mem_d[wr_ptr_q] = push_dest;
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + CNT_W'(store) - CNT_W'(pop_hs);
      dup_d   = push_hs & hit;
      ovf_d   = push_valid & full;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dup_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dup_q    <= dup_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cola_destinos_fifo.sv
// ============================================================================
// tb_cola_destinos_fifo : directed table plus random traffic against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cola_destinos_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 2;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n, flush, push_valid, pop_ready;
  logic [DW-1:0] push_dest;

  logic          push_ready1, pop_valid1, full1, empty1, dup1, ovf1;
  logic [DW-1:0] destino1;
  logic [CW-1:0] count1;
  logic          push_ready0, pop_valid0, full0, empty0, dup0, ovf0;
  logic [DW-1:0] destino0;
  logic [CW-1:0] count0;

  always #5 clk = ~clk;

  cola_destinos_fifo #(.DEST_W(DW), .DEPTH(DEPTH), .DEDUP(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid), .push_dest(push_dest),
    .push_ready(push_ready1), .pop_valid(pop_valid1), .pop_ready(pop_ready), .destino(destino1),
    .count(count1), .full(full1), .empty(empty1), .duplicado(dup1), .overflow(ovf1));

  cola_destinos_fifo #(.DEST_W(DW), .DEPTH(DEPTH), .DEDUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid), .push_dest(push_dest),
    .push_ready(push_ready0), .pop_valid(pop_valid0), .pop_ready(pop_ready), .destino(destino0),
    .count(count0), .full(full0), .empty(empty0), .duplicado(dup0), .overflow(ovf0));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain queues of pending codes plus last-cycle flag values.
  int q1[$];
  int q0[$];
  bit m_dup1, m_ovf1, m_dup0, m_ovf0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input int q[$], input int v, input bit skip_head);
    for (int i = (skip_head ? 1 : 0); i < q.size(); i++)
      if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_model();
    chk("count1",  int'(count1),   q1.size());
    chk("destino1", int'(destino1), q1.size() > 0 ? q1[0] : 0);
    chk("pop_valid1", int'(pop_valid1), q1.size() > 0);
    chk("push_ready1", int'(push_ready1), q1.size() < DEPTH);
    chk("full1",   int'(full1),    q1.size() == DEPTH);
    chk("empty1",  int'(empty1),   q1.size() == 0);
    chk("dup1",    int'(dup1),     int'(m_dup1));
    chk("ovf1",    int'(ovf1),     int'(m_ovf1));
    chk("count0",  int'(count0),   q0.size());
    chk("destino0", int'(destino0), q0.size() > 0 ? q0[0] : 0);
    chk("full0",   int'(full0),    q0.size() == DEPTH);
    chk("empty0",  int'(empty0),   q0.size() == 0);
    chk("dup0",    int'(dup0),     int'(m_dup0));
    chk("ovf0",    int'(ovf0),     int'(m_ovf0));
  endtask

  task automatic update_model(input bit pv, input int d, input bit pr, input bit fl);
    bit pop, ok, dup;
    if (fl) begin
      q1.delete(); q0.delete();
      m_dup1 = 0; m_ovf1 = 0; m_dup0 = 0; m_ovf0 = 0;
      return;
    end
    pop = pr && q1.size() > 0;
    ok  = pv && q1.size() < DEPTH;
    dup = ok && pending(q1, d, pop);
    m_ovf1 = pv && q1.size() == DEPTH;
    m_dup1 = dup;
    if (pop) void'(q1.pop_front());
    if (ok && !dup) q1.push_back(d);
    pop = pr && q0.size() > 0;
    ok  = pv && q0.size() < DEPTH;
    m_ovf0 = pv && q0.size() == DEPTH;
    m_dup0 = 0;
    if (pop) void'(q0.pop_front());
    if (ok) q0.push_back(d);
  endtask

  task automatic step(input bit pv, input logic [1:0] d, input bit pr, input bit fl);
    push_valid = pv; push_dest = d; pop_ready = pr; flush = fl;
    #1;
    check_model();
    @(posedge clk);
    update_model(pv, int'(d), pr, fl);
    #1;
  endtask

  typedef struct {
    bit pv; logic [1:0] d; bit pr; bit fl;
    int cnt; int dst; bit dup; bit ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit pv, logic [1:0] d, bit pr, bit fl, int cnt, int dst, bit dup, bit ovf);
    vec_t v;
    v.pv = pv; v.d = d; v.pr = pr; v.fl = fl;
    v.cnt = cnt; v.dst = dst; v.dup = dup; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    // Expected values are for the DEDUP=1 instance, observed after the edge.
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 3, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 2, 3, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 3, 3, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 4, 3, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 4, 3, 0, 1));
    tbl.push_back(mk(1, 2'b10, 1, 0, 3, 0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 2, 2, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 3, 2, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 3, 2, 1, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 3, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 1, 2, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 2, 2, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(1, 2'b10, 1, 0, 2, 3, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 0, 2, 2, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 1, 0, 1, 3, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 2, 3, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 3, 3, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 1, 0, 0, 0, 0));

    rst_n = 1'b0; flush = 0; push_valid = 0; pop_ready = 0; push_dest = '0;
    m_dup1 = 0; m_ovf1 = 0; m_dup0 = 0; m_ovf0 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", int'(empty1), 1);
    chk("rst_full", int'(full1), 0);
    chk("rst_count", int'(count1), 0);
    chk("rst_push_ready", int'(push_ready1), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].pv, tbl[i].d, tbl[i].pr, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), int'(count1), tbl[i].cnt);
      chk($sformatf("tbl%0d_destino", i), int'(destino1), tbl[i].dst);
      chk($sformatf("tbl%0d_dup", i), int'(dup1), int'(tbl[i].dup));
      chk($sformatf("tbl%0d_ovf", i), int'(ovf1), int'(tbl[i].ovf));
    end

    // DEDUP=0 keeps a repeated code.
    step(1, 2'b10, 0, 0);
    step(1, 2'b10, 0, 0);
    chk("nodedup_count", int'(count0), 2);
    chk("dedup_count", int'(count1), 1);

    // Asynchronous reset asserted between edges.
    step(1, 2'b11, 0, 0);
    push_valid = 0; pop_ready = 0; flush = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_empty", int'(empty1), 1);
    chk("async_count", int'(count1), 0);
    chk("async_destino", int'(destino1), 0);
    chk("async_pop_valid", int'(pop_valid1), 0);
    chk("async_count0", int'(count0), 0);
    q1.delete(); q0.delete();
    m_dup1 = 0; m_ovf1 = 0; m_dup0 = 0; m_ovf0 = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    step(0, 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
